// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result bundle for the binary32 multiplier
interface fp_mul_pipe_if;
    logic [2:0]  r_mode;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;

    modport master (output r_mode, fp_X, fp_Y, input fp_Z, ovrf, udrf);
    modport slave  (input r_mode, fp_X, fp_Y, output fp_Z, ovrf, udrf);
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - binary32 multiplier, combinational datapath, registered result
module fp_mul_pipe (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam logic [2:0] MODE_RNE = 3'b000;
    localparam logic [2:0] MODE_RTZ = 3'b001;
    localparam logic [2:0] MODE_RDN = 3'b010;
    localparam logic [2:0] MODE_RUP = 3'b011;
    localparam logic [2:0] MODE_RMM = 3'b100;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [30:0] INF_MAG = 31'h7F800000;
    localparam logic [30:0] MAX_MAG = 31'h7F7FFFFF;

    logic        w_sx, w_sy, w_sz;
    logic [7:0]  w_ex, w_ey;
    logic [22:0] w_fx, w_fy;
    logic        w_nan_x, w_nan_y, w_inf_x, w_inf_y, w_zero_x, w_zero_y;

    assign w_sx = bus.fp_X[31];
    assign w_sy = bus.fp_Y[31];
    assign w_ex = bus.fp_X[30:23];
    assign w_ey = bus.fp_Y[30:23];
    assign w_fx = bus.fp_X[22:0];
    assign w_fy = bus.fp_Y[22:0];
    assign w_sz = w_sx ^ w_sy;

    // Exponent zero covers both true zero and subnormals (flush-to-zero).
    assign w_nan_x  = (w_ex == 8'hFF) && (w_fx != 23'd0);
    assign w_nan_y  = (w_ey == 8'hFF) && (w_fy != 23'd0);
    assign w_inf_x  = (w_ex == 8'hFF) && (w_fx == 23'd0);
    assign w_inf_y  = (w_ey == 8'hFF) && (w_fy == 23'd0);
    assign w_zero_x = (w_ex == 8'h00);
    assign w_zero_y = (w_ey == 8'h00);

    logic [47:0]       w_prod;
    logic signed [9:0] w_e_prov, w_e_norm, w_e_rnd;
    logic [22:0]       w_kept;
    logic              w_guard, w_sticky, w_inc;
    logic [24:0]       w_sum;
    logic [22:0]       w_frac;

    assign w_prod   = {1'b1, w_fx} * {1'b1, w_fy};
    assign w_e_prov = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - 10'sd127;
    assign w_e_norm = w_prod[47] ? (w_e_prov + 10'sd1) : w_e_prov;

    always_comb begin
        if (w_prod[47]) begin
            w_kept   = w_prod[46:24];
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
        end else begin
            w_kept   = w_prod[45:23];
            w_guard  = w_prod[22];
            w_sticky = |w_prod[21:0];
        end
    end

    always_comb begin
        w_inc = 1'b0;
        case (bus.r_mode)
            MODE_RTZ: w_inc = 1'b0;
            MODE_RDN: w_inc = (w_guard | w_sticky) & w_sz;
            MODE_RUP: w_inc = (w_guard | w_sticky) & ~w_sz;
            MODE_RMM: w_inc = w_guard;
            default:  w_inc = w_guard & (w_kept[0] | w_sticky);
        endcase
    end

    // On carry-out the sum is exactly 2^24, so the upper slice is all zeros.
    assign w_sum   = {1'b0, 1'b1, w_kept} + {24'd0, w_inc};
    assign w_frac  = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_e_rnd = w_e_norm + $signed({9'd0, w_sum[24]});

    logic [30:0] w_ovf_mag;

    always_comb begin
        w_ovf_mag = INF_MAG;
        case (bus.r_mode)
            MODE_RTZ: w_ovf_mag = MAX_MAG;
            MODE_RDN: w_ovf_mag = w_sz ? INF_MAG : MAX_MAG;
            MODE_RUP: w_ovf_mag = w_sz ? MAX_MAG : INF_MAG;
            default:  w_ovf_mag = INF_MAG;
        endcase
    end

    logic [31:0] w_z;
    logic        w_ovrf, w_udrf;

    always_comb begin
        w_z    = {w_sz, w_e_rnd[7:0], w_frac};
        w_ovrf = 1'b0;
        w_udrf = 1'b0;
        if (w_nan_x || w_nan_y) begin
            w_z = QNAN;
        end else if ((w_inf_x && w_zero_y) || (w_zero_x && w_inf_y)) begin
            w_z = QNAN;
        end else if (w_inf_x || w_inf_y) begin
            w_z = {w_sz, INF_MAG};
        end else if (w_zero_x || w_zero_y) begin
            w_z = {w_sz, 31'd0};
        end else if (w_e_norm < 10'sd1) begin
            w_z    = {w_sz, 31'd0};
            w_udrf = 1'b1;
        end else if (w_e_rnd > 10'sd254) begin
            w_z    = {w_sz, w_ovf_mag};
            w_ovrf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fp_Z <= 32'h00000000;
            bus.ovrf <= 1'b0;
            bus.udrf <= 1'b0;
        end else begin
            bus.fp_Z <= w_z;
            bus.ovrf <= w_ovrf;
            bus.udrf <= w_udrf;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_mul_pipe_if bus();

    fp_mul_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          passed = 0;
    int          total  = 0;
    logic [31:0] prev_z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Drive one operation; output must still hold the previous result until the edge.
    task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [2:0] mode, input logic [31:0] ez,
                      input logic eo, input logic eu);
        @(negedge clk);
        bus.fp_X   = x;
        bus.fp_Y   = y;
        bus.r_mode = mode;
        #1;
        check({tag, "/hold"}, bus.fp_Z, prev_z);
        @(posedge clk);
        #1;
        check({tag, "/z"}, bus.fp_Z, ez);
        check({tag, "/ovrf"}, {31'd0, bus.ovrf}, {31'd0, eo});
        check({tag, "/udrf"}, {31'd0, bus.udrf}, {31'd0, eu});
        prev_z = ez;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.fp_X   = 32'h0;
        bus.fp_Y   = 32'h0;
        bus.r_mode = 3'b000;
        #2;
        check("reset/z", bus.fp_Z, 32'h0);
        check("reset/ovrf", {31'd0, bus.ovrf}, 32'd0);
        check("reset/udrf", {31'd0, bus.udrf}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        prev_z = 32'h0;

        op("n1", 32'h3F800000, 32'h40000000, 3'b000, 32'h40000000, 1'b0, 1'b0);
        op("n2", 32'h40400000, 32'h40800000, 3'b000, 32'h41400000, 1'b0, 1'b0);
        op("n3", 32'hC2480000, 32'h42C80000, 3'b000, 32'hC59C4000, 1'b0, 1'b0);
        op("n4", 32'h3EAAAA3B, 32'h3EAAAA3B, 3'b000, 32'h3DE38D0F, 1'b0, 1'b0);
        op("n5", 32'h3E000000, 32'h3DCCCCCD, 3'b000, 32'h3C4CCCCD, 1'b0, 1'b0);
        op("n6", 32'h41200000, 32'hC1200000, 3'b000, 32'hC2C80000, 1'b0, 1'b0);

        op("s_infzero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0);
        op("s_ninfinf", 32'hFF800000, 32'h7F800000, 3'b000, 32'hFF800000, 1'b0, 1'b0);
        op("s_ninfninf", 32'hFF800000, 32'hFF800000, 3'b000, 32'h7F800000, 1'b0, 1'b0);
        op("s_nan", 32'h7FC00000, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0);
        op("s_nzero", 32'h80000000, 32'h00000000, 3'b000, 32'h80000000, 1'b0, 1'b0);
        op("s_nznz", 32'h80000000, 32'h80000000, 3'b000, 32'h00000000, 1'b0, 1'b0);

        op("ov_rne", 32'h7F000000, 32'h40000000, 3'b000, 32'h7F800000, 1'b1, 1'b0);
        op("ov_rtz", 32'h7F000000, 32'h40000000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0);
        op("ov_rdn", 32'hFF000000, 32'h40000000, 3'b010, 32'hFF800000, 1'b1, 1'b0);
        op("ov_rup", 32'hFF000000, 32'h40000000, 3'b011, 32'hFF7FFFFF, 1'b1, 1'b0);

        op("uf", 32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 1'b0, 1'b1);
        op("subn", 32'h00000001, 32'h3F800000, 3'b000, 32'h00000000, 1'b0, 1'b0);

        op("r_rne", 32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 1'b0, 1'b0);
        op("r_rup", 32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 1'b0, 1'b0);
        op("r_rtz", 32'h3F800001, 32'h3F800001, 3'b001, 32'h3F800002, 1'b0, 1'b0);

        op("pre_rst", 32'h40400000, 32'h40800000, 3'b000, 32'h41400000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async/z", bus.fp_Z, 32'h0);
        check("rst_async/flags", {30'd0, bus.ovrf, bus.udrf}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held/z", bus.fp_Z, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release/z", bus.fp_Z, 32'h0);
        @(posedge clk);
        #1;
        check("rst_after/z", bus.fp_Z, 32'h41400000);
        check("rst_after/flags", {30'd0, bus.ovrf, bus.udrf}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- IEEE-754 binary32 multiplier with a selectable rounding mode and overflow/underflow flags.
- Datapath from operands to rounded result is combinational; result and flags are registered once.
- Sits in the FP ALU as the multiply unit, alongside the adder.
- Subnormals are handled flush-to-zero: subnormal inputs are treated as zero, and tiny results are flushed.

Parameters:
- None. Format is fixed at binary32: 1 sign bit, 8 exponent bits with bias 127, 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- r_mode  input  3  rounding mode:
  - 000 RNE (round to nearest, ties to even)
  - 001 RTZ (toward zero)
  - 010 RDN (toward −inf)
  - 011 RUP (toward +inf)
  - 100 RMM (nearest, ties away from zero)
  - 101–111 behave as RNE
- fp_X  input  32  operand X
- fp_Y  input  32  operand Y
- fp_Z  output  32  product, registered
- ovrf  output  1  overflow flag, registered
- udrf  output  1  underflow flag, registered

Behaviour:
- Reset: while rst_n=0, asynchronously fp_Z=32'h00000000, ovrf=0, udrf=0.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on fp_Z/ovrf/udrf after edge N.
- No handshake. A new operation is accepted every cycle, and outputs update every cycle.
- Sign: sZ = sX XOR sY for every non-NaN result, including zeros and infinities.
- Special cases, checked in priority order:
  1. Either operand NaN (exp=FF, frac≠0) → 7FC00000.
  2. Inf × zero, in either order → 7FC00000.
  3. Either operand Inf → signed Inf (7F800000 or FF800000).
  4. Either operand zero or subnormal → signed zero.
  - In all special cases ovrf=0 and udrf=0.
- Normal path:
  - Significands are 1.f (24 bits). Form the 48-bit product P.
  - Provisional exponent E = eX + eY − 127.
  - If P[47]=1: shift right by 1 and E=E+1.
  - Keep 23 fraction bits. Guard = next bit; sticky = OR of all remaining bits.
- Rounding increment:
  - RNE: G & (L | S), where L = LSB of the kept fraction.
  - RTZ: never.
  - RDN: (G|S) & sign.
  - RUP: (G|S) & ~sign.
  - RMM: G.
- If the increment carries out of the significand: fraction = 0 and E=E+1.
- Underflow: tininess is detected before rounding. If E < 1 → signed zero, udrf=1, ovrf=0.
- Overflow: if E > 254 after rounding → ovrf=1, udrf=0. Result depends on mode:
  - RNE, RMM: signed Inf.
  - RTZ: signed max finite (7F7FFFFF / FF7FFFFF).
  - RDN: +max finite if positive, −Inf if negative.
  - RUP: +Inf if positive, −max finite if negative.
- Otherwise fp_Z = {sZ, E[7:0], frac} with ovrf=0 and udrf=0.
- Reset asserted mid-stream: outputs are cleared immediately. The first valid result appears one edge after rst_n deasserts.
- Internal widths:
  - Exponent arithmetic uses at least 10-bit signed values, so the underflow and overflow ranges never wrap.
  - The product is 48 bits. The rounding adder is 24 bits plus carry.

Test Plan:
- Normal values, RNE, one value per cycle: each result must appear one cycle after its inputs.
  - 3F800000×40000000 → 40000000
  - 40400000×40800000 → 41400000
  - C2480000×42C80000 → C59C4000
  - 3EAAAA3B×3EAAAA3B → 3DE38D0F
  - 3E000000×3DCCCCCD → 3C4CCCCD
  - 41200000×C1200000 → C2C80000
  - All with ovrf=udrf=0.
- Specials:
  - 7F800000×00000000 → 7FC00000
  - FF800000×7F800000 → FF800000
  - FF800000×FF800000 → 7F800000
  - 7FC00000×3F800000 → 7FC00000
  - 80000000×00000000 → 80000000
  - 80000000×80000000 → 00000000
  - All with flags 0.
- Overflow, 7F000000×40000000:
  - RNE → 7F800000, ovrf=1
  - RTZ → 7F7FFFFF, ovrf=1
  - With X negated (FF000000): RDN → FF800000; RUP → FF7FFFFF.
- Underflow: 00800000×3F000000 → 00000000, udrf=1. Subnormal input 00000001×3F800000 → 00000000 with udrf=0.
- Rounding modes on 3F800001×3F800001 (exact 1+2⁻²²+2⁻⁴⁶):
  - RNE → 3F800002
  - RUP → 3F800003
  - RTZ → 3F800002
- Reset: drive 40400000×40800000, assert rst_n=0 asynchronously between clock edges.
  - Required: fp_Z=00000000 and flags 0 immediately.
  - After deassert: 41400000 appears one edge later.
